poly_feeder: RTL



---
 rtl/poly_feeder_pkg.sv | 19 +
 rtl/poly_feeder.sv | 116 +++++++++++
 2 files changed

// File: rtl/poly_feeder_pkg.sv
// Shared definitions for the polynomial evaluator feeder.
//   DATA_W        operand / result width
//   NUM_OPERANDS  operands per evaluation (A, B, C, X)
//   state_t       feeder FSM state encoding
package poly_feeder_pkg;

  localparam int DATA_W       = 8;
  localparam int NUM_OPERANDS = 4;

  typedef enum logic [2:0] {
    ST_COLLECT  = 3'd0,
    ST_DRIVE_HI = 3'd1,
    ST_DRIVE_LO = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_ACK      = 3'd4,
    ST_OUT      = 3'd5
  } state_t;

endpackage

// File: rtl/poly_feeder.sv
// poly_feeder: collects four operand bytes (A, B, C, X) from a valid/ready
// stream, steps them one by one into a polynomial evaluator using a go
// pulse per operand, waits for the evaluator result, acknowledges it with
// one more go pulse and presents the captured byte on a valid/ready output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; ready never depends on valid, and a presented out_data is
// held unchanged until it is taken.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_data    operand byte stream, in_ready = accept
//   go, data_in         step pulse and operand towards the evaluator
//   result_valid,       evaluator result strobe and value
//   data_result
//   out_valid/out_data  captured result, out_ready = taken
//   busy                high whenever not collecting operands
//   dbg_state, dbg_idx  current FSM state and operand index
module poly_feeder
  import poly_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              go,
  output logic [DATA_W-1:0] data_in,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] data_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [2:0]        dbg_state,
  output logic [1:0]        dbg_idx
);

  localparam logic [2:0] COLLECT  = ST_COLLECT;
  localparam logic [2:0] DRIVE_HI = ST_DRIVE_HI;
  localparam logic [2:0] DRIVE_LO = ST_DRIVE_LO;
  localparam logic [2:0] WAIT_RES = ST_WAIT_RES;
  localparam logic [2:0] ACK      = ST_ACK;
  localparam logic [2:0] OUT      = ST_OUT;

  logic [2:0]        state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [DATA_W-1:0] ops [NUM_OPERANDS];
  logic              in_fire;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == OUT);
  assign busy      = (state != COLLECT);
  assign in_fire   = in_valid & in_ready;
  assign dbg_state = state;
  assign dbg_idx   = idx;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      COLLECT: begin
        if (in_fire) begin
          // 2-bit index wraps to 0 after the fourth operand.
          idx_nxt = idx + 2'd1;
          if (idx == 2'd3) state_nxt = DRIVE_HI;
        end
      end
      DRIVE_HI: state_nxt = DRIVE_LO;
      DRIVE_LO: begin
        if (idx == 2'd3) begin
          state_nxt = WAIT_RES;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = DRIVE_HI;
        end
      end
      WAIT_RES: if (result_valid) state_nxt = ACK;
      ACK:      state_nxt = OUT;
      OUT: begin
        if (out_ready) begin
          state_nxt = COLLECT;
          idx_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = COLLECT;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      idx      <= 2'd0;
      go       <= 1'b0;
      data_in  <= '0;
      out_data <= '0;
      for (int i = 0; i < NUM_OPERANDS; i++) ops[i] <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (in_fire) ops[idx] <= in_data;
      // go is a flop decoded from the next state, so it is glitch-free and
      // high exactly during the DRIVE_HI and ACK cycles.
      go <= (state_nxt == DRIVE_HI) || (state_nxt == ACK);
      // Operand only changes on entry to DRIVE_HI, keeping it stable across
      // the whole hi/lo pair. On the COLLECT exit idx_nxt is 0, whose slot
      // was written on an earlier accept.
      if (state_nxt == DRIVE_HI) data_in <= ops[idx_nxt];
      if ((state == WAIT_RES) && result_valid) out_data <= data_result;
    end
  end

endmodule
